// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, the decryption controller FSM states and the
// byte-slice helpers for the column-major 128-bit state layout.
package aes_pkg;

   localparam int NR_AES128 = 10;
   localparam int STATE_W   = 128;

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} dec_fsm_e;

   // Byte n = 4*col + row lives at [127-8n -: 8]; this returns its LSB position.
   function automatic int byte_lsb(input int row, input int col);
      return STATE_W - 8 - 8 * (4 * col + row);
   endfunction

   function automatic logic [7:0] get_byte(input logic [STATE_W-1:0] s,
                                           input int row, input int col);
      return s[byte_lsb(row, col) +: 8];
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and
// InvMixColumns, with the column mix bypassed for the last round.
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [STATE_W-1:0] state,
   input  logic [STATE_W-1:0] rkey,
   input  logic               skip_mix,
   output logic [STATE_W-1:0] result
);

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Inverse S-box as inverse affine map followed by GF(2^8) inversion (x^254).
   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      logic [7:0] b;
      logic [7:0] sq;
      logic [7:0] acc;
      b   = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
      sq  = b;
      acc = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq  = gmul(sq, sq);
         acc = gmul(acc, sq);
      end
      return acc;
   endfunction

   logic [STATE_W-1:0] shifted, subbed, keyed, mixed;
   logic [7:0]         a0, a1, a2, a3;

   // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      shifted = '0;
      subbed  = '0;
      mixed   = '0;
      a0 = 8'h00;
      a1 = 8'h00;
      a2 = 8'h00;
      a3 = 8'h00;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            shifted[byte_lsb(r, c) +: 8] = get_byte(state, r, (c + 4 - r) % 4);
      for (int n = 0; n < 16; n++)
         subbed[8*n +: 8] = inv_sbox(shifted[8*n +: 8]);
      keyed = subbed ^ rkey;
      for (int c = 0; c < 4; c++) begin
         a0 = get_byte(keyed, 0, c);
         a1 = get_byte(keyed, 1, c);
         a2 = get_byte(keyed, 2, c);
         a3 = get_byte(keyed, 3, c);
         mixed[byte_lsb(0, c) +: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         mixed[byte_lsb(1, c) +: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         mixed[byte_lsb(2, c) +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         mixed[byte_lsb(3, c) +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
   end

   assign result = skip_mix ? keyed : mixed;

endmodule

// File: rtl/aes_dec_round_ctrl.sv
// Iterative AES-128 decryption controller: one inverse round per clock, round
// keys fetched by index from the external key-schedule store.
module aes_dec_round_ctrl
   import aes_pkg::*;
#(
   parameter int NR       = NR_AES128,
   parameter int RK_IDX_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [STATE_W-1:0]  in_data,
   output logic [RK_IDX_W-1:0] rk_idx,
   input  logic [STATE_W-1:0]  rk_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [STATE_W-1:0]  out_data,
   output logic                busy
);

   dec_fsm_e            fsm, fsm_nxt;
   logic [STATE_W-1:0]  state, state_nxt, round_out;
   logic [RK_IDX_W-1:0] round, round_nxt;
   logic                skip_mix;

   aes_inv_round u_inv_round (
      .state    (state),
      .rkey     (rk_data),
      .skip_mix (skip_mix),
      .result   (round_out)
   );

   // NOTE: the data register is reset too, so an aborted block leaves no partial plaintext behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm   <= IDLE;
         state <= '0;
         round <= '0;
      end else begin
         fsm   <= fsm_nxt;
         state <= state_nxt;
         round <= round_nxt;
      end
   end

   always_comb begin
      fsm_nxt   = fsm;
      state_nxt = state;
      round_nxt = round;
      rk_idx    = '0;
      skip_mix  = 1'b0;
      out_valid = 1'b0;
      unique case (fsm)
         IDLE: begin
            rk_idx = RK_IDX_W'(NR);
            if (in_valid && in_ready) begin
               state_nxt = in_data ^ rk_data;
               round_nxt = RK_IDX_W'(NR - 1);
               fsm_nxt   = ROUND;
            end
         end
         ROUND: begin
            rk_idx    = round;
            state_nxt = round_out;
            round_nxt = round - RK_IDX_W'(1);
            if (round == RK_IDX_W'(1)) fsm_nxt = FINAL;
         end
         FINAL: begin
            skip_mix  = 1'b1;
            state_nxt = round_out;
            fsm_nxt   = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) fsm_nxt = IDLE;
         end
         default: fsm_nxt = IDLE;
      endcase
   end

   // Held low during reset so nothing is offered before the controller is live.
   assign in_ready = (fsm == IDLE) && !rst;
   assign busy     = (fsm != IDLE);
   assign out_data = state;

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Bench for aes_dec_round_ctrl, with its own forward AES-128 and key schedule
// supplying the key-store rows and the ciphertext/plaintext pairs.
module tb_aes_dec_round_ctrl;

   localparam int NR       = 10;
   localparam int RK_IDX_W = 4;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [127:0]        in_data = '0;
   logic [RK_IDX_W-1:0] rk_idx;
   logic [127:0]        rk_data;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic [127:0]        out_data;
   logic                busy;

   always #5 clk = ~clk;

   aes_dec_round_ctrl #(.NR(NR), .RK_IDX_W(RK_IDX_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .rk_idx    (rk_idx),
      .rk_data   (rk_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   logic [7:0]   sbox [256];
   logic [127:0] ks [16];
   assign rk_data = ks[rk_idx];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int dut_hs = 0;
   int m_hs   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // ---------------- forward AES reference ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int s);
      return (x << s) | (x >> (8 - s));
   endfunction

   task automatic build_tables(input logic [127:0] key);
      logic [7:0]  p, q, rc;
      logic [31:0] w [44];
      logic [31:0] t;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if (q[7]) q = q ^ 8'h09;
         sbox[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
      end while (p != 8'h01);
      sbox[0] = 8'h63;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 16; r++) ks[r] = '0;
      for (int r = 0; r <= NR; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] aes_enc(input logic [127:0] pt);
      logic [127:0] s;
      logic [7:0]   b [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      s = pt ^ ks[0];
      for (int r = 1; r <= NR; r++) begin
         for (int n = 0; n < 16; n++) t[n] = sbox[s[127 - 8*n -: 8]];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
               b[4*c + row] = t[4*((c + row) % 4) + row];
         if (r != NR) begin
            for (int c = 0; c < 4; c++) begin
               a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
               b[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               b[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               b[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               b[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end
         for (int n = 0; n < 16; n++) s[127 - 8*n -: 8] = b[n];
         s = s ^ ks[r];
      end
      return s;
   endfunction

   // ---------------- transaction-level timing model ----------------
   // age: -1 when idle, otherwise clock edges since the accepting edge.
   int           age    = -1;
   bit           m_zero = 1'b1;
   logic [127:0] drv_pt = '0;
   logic [127:0] exp_q [$];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         age    <= -1;
         m_zero <= 1'b1;
         exp_q.delete();
      end else if (age < 0) begin
         if (in_valid) begin
            age    <= 1;
            m_zero <= 1'b0;
            exp_q.push_back(drv_pt);
         end
      end else if (age <= NR) begin
         age <= age + 1;
      end else if (out_ready) begin
         age  <= -1;
         m_hs <= m_hs + 1;
         void'(exp_q.pop_front());
      end
   end

   function automatic int rk_exp(input int a);
      if (a < 0) return NR;
      if (a < NR) return NR - a;
      return 0;
   endfunction

   always @(negedge clk) begin
      check("in_ready", in_ready, !rst && age < 0);
      check("busy", busy, !rst && age >= 0);
      check("out_valid", out_valid, !rst && age > NR);
      check("rk_idx", rk_idx, rk_exp(age));
      if (age > NR && exp_q.size() > 0) check("out_data", out_data, exp_q[0]);
      if (m_zero) check("cleared state", out_data, '0);
      if (out_valid && out_ready && !rst) dut_hs <= dut_hs + 1;
   end

   // ---------------- directed stimulus ----------------
   task automatic send(input logic [127:0] ct, input logic [127:0] pt,
                       output int acc_cyc, output int first_rk);
      int n;
      in_valid = 1'b1;
      in_data  = ct;
      drv_pt   = pt;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("in_ready before accept", in_ready, 1'b1);
      acc_cyc  = cyc;
      first_rk = rk_idx;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_valid(input int budget);
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("out_valid arrival", out_valid, 1'b1);
   endtask

   localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] PT2 = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [127:0] PT3 = 128'h0123456789abcdeffedcba9876543210;

   initial begin
      int           acc_a, acc_b, first_rk, n, hs0;
      int           rk_seq [$];
      logic [127:0] ct2, ct3;

      build_tables(KEY);
      check("model sbox[53]", sbox[8'h53], 8'hed);
      check("model rk10", ks[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
      check("model C.1 encrypt", aes_enc(PT1), CT1);
      ct2 = aes_enc(PT2);
      ct3 = aes_enc(PT3);

      // Reset values while rst is held
      repeat (2) @(negedge clk);
      check("reset in_ready", in_ready, 1'b0);
      check("reset busy", busy, 1'b0);
      check("reset out_valid", out_valid, 1'b0);
      check("reset rk_idx", rk_idx, 4'd10);
      check("reset out_data", out_data, '0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("in_ready after release", in_ready, 1'b1);

      // C.1 vector, out_ready already high: latency, rk_idx sequence, 1-cycle transfer
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      send(CT1, PT1, acc_a, first_rk);
      rk_seq.push_back(first_rk);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 30) begin
         rk_seq.push_back(rk_idx);
         @(negedge clk);
         n++;
      end
      check("latency edges", cyc - (acc_a + 1), NR);
      check("C.1 plaintext", out_data, PT1);
      check("rk_idx sequence length", rk_seq.size(), NR + 1);
      foreach (rk_seq[i]) check("rk_idx sequence", rk_seq[i], NR - i);
      @(negedge clk);
      check("after transfer out_valid", out_valid, 1'b0);
      check("after transfer in_ready", in_ready, 1'b1);

      // Back-pressure in DONE
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(ct2, PT2, acc_a, first_rk);
      wait_valid(20);
      repeat (5) begin
         @(negedge clk);
         check("stall out_valid", out_valid, 1'b1);
         check("stall out_data", out_data, PT2);
         check("stall in_ready", in_ready, 1'b0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      check("release still DONE", out_valid, 1'b1);
      @(negedge clk);
      check("release idle busy", busy, 1'b0);
      check("release idle in_ready", in_ready, 1'b1);

      // Second block queued behind the first
      @(posedge clk);
      #1;
      send(ct3, PT3, acc_a, first_rk);
      send(CT1, PT1, acc_b, first_rk);
      check("queued accept spacing", acc_b - acc_a, NR + 2);
      wait_valid(20);
      check("queued second plaintext", out_data, PT1);
      @(negedge clk);

      // Reset in the middle of a block
      @(posedge clk);
      #1 hs0 = dut_hs;
      send(CT1, PT1, acc_a, first_rk);
      n = 0;
      @(negedge clk);
      while (rk_idx != 4'd5 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("reached round 5", rk_idx, 4'd5);
      #1 rst = 1'b1;
      @(negedge clk);
      check("abort busy", busy, 1'b0);
      check("abort out_valid", out_valid, 1'b0);
      check("abort state", out_data, '0);
      check("abort in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (15) @(negedge clk);
      check("no output after abort", dut_hs, hs0);
      @(posedge clk);
      #1;
      send(CT1, PT1, acc_a, first_rk);
      wait_valid(20);
      check("C.1 after reset", out_data, PT1);
      repeat (3) @(negedge clk);
      check("handshake count", dut_hs, m_hs);
      check("total handshakes", dut_hs, 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/aes_dec_round_ctrl.md
# aes_dec_round_ctrl

Iterative AES-128 decryption controller: accepts one 128-bit ciphertext block over a valid/ready handshake and sequences the inverse-round datapath once per clock. The datapath is inverse ShiftRows, inverse SubBytes, AddRoundKey and InvMixColumns. The block fetches round keys by index from the external key-schedule store and returns the plaintext over a second valid/ready handshake. It sits between the decryption top-level I/O and the key-expansion block, and owns the round counter and the state register.

## Interface
- NR, 10, number of AES rounds; fixed for AES-128, kept as a parameter for the range checks.
- RK_IDX_W, 4, width of the round-key index; must satisfy 2^RK_IDX_W > NR.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  ciphertext block present on in_data.
- in_ready  output  1  block can accept a ciphertext this cycle.
- in_data  input  128  ciphertext; byte 0 at [127:120], column-major, same byte order as the existing ShiftRows modules.
- rk_idx  output  RK_IDX_W  round-key index requested this cycle.
- rk_data  input  128  round key for rk_idx; combinational, same-cycle read.
- out_valid  output  1  plaintext present on out_data.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  128  plaintext; equals the state register.
- busy  output  1  high in every state other than IDLE.

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE. Registers: state[127:0], round[RK_IDX_W-1:0].
- **IDLE**
  - in_ready=1 and rk_idx=NR.
  - When in_valid & in_ready: state <= in_data ^ rk_data, round <= NR-1, next state is ROUND.
- **ROUND**
  - rk_idx=round.
  - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_data).
  - round <= round-1.
  - When round==1, next state is FINAL; otherwise stay in ROUND.
- **FINAL**
  - rk_idx=0.
  - state <= InvSubBytes(InvShiftRows(state)) ^ rk_data.
  - Next state is DONE.
- **DONE**
  - out_valid=1, rk_idx=0.
  - When out_ready, next state is IDLE. Otherwise hold, with state and out_data stable.
- Handshake rules:
  - in_ready is 0 in all states other than IDLE. A block presented while busy waits; it is never dropped or overwritten.
  - No accept in the same cycle as an output handshake. The next block is accepted no earlier than the first IDLE cycle.
- round never underflows: it decrements only in ROUND, where round ≥ 1 always holds.
- Widths: every XOR and byte operation is exactly 128 bits, with no truncation. rk_idx is zero-extended from round.

## Timing
- Reset values (asynchronous, while rst=1 and on release):
  - FSM=IDLE, state=0, round=0.
  - out_valid=0, busy=0, rk_idx=NR.
  - in_ready=0 while rst is high; 1 in the first cycle after release.
- Latency: with the accept on edge 0, out_valid rises after edge NR (10 cycles).
- rk_idx sequence per block: 10 (IDLE), 9…1 (ROUND), 0 (FINAL).
- Minimum block period: NR+2 cycles (accept cycle, 9 ROUND, 1 FINAL, 1 DONE handshake), given continuous in_valid and out_ready.
- Reset mid-operation: the block aborts immediately with no output, and the partial state is cleared to 0.
- out_valid and out_ready high on the same edge complete the transfer. out_valid is 0 in the following cycle.

## Structure
- Shared package aes_pkg holds:
  - NR_AES128=10 and STATE_W=128.
  - The FSM state enum {IDLE, ROUND, FINAL, DONE}.
  - The byte-slice index helpers used by the ShiftRows modules.
- One combinational sub-module, aes_inv_round:
  - Inputs: state, round key, skip_mix.
  - It instantiates the existing inverse ShiftRows, an inverse S-box per byte, and InvMixColumns, with InvMixColumns bypassed when skip_mix=1.
  - The IDLE AddRoundKey stays a plain XOR in the controller.

## Test plan
- FIPS-197 C.1 vector:
  - Stimulus: key-store rows from key 000102030405060708090a0b0c0d0e0f (rk10=13111d7fe3944a17f307a78b4d2b30c5), ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: out_data=00112233445566778899aabbccddeeff exactly 10 cycles after accept, and rk_idx sequence 10,9,…,1,0.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE → out_valid stays 1, out_data stays stable, in_ready stays 0. Release it → IDLE on the next edge.
- Queued input: hold in_valid=1 with a second block during the first decryption → the second block is accepted in the first IDLE cycle (cycle 12), and both plaintexts are correct and in order.
- Reset mid-round: assert rst while round=5 → out_valid=0, busy=0, state=0, and no output handshake. After release, the C.1 vector decrypts correctly.
- Same-cycle handshake: out_ready=1 already when out_valid rises → transfer completes in 1 cycle, then in_ready=1 and out_valid=0 on the next cycle.
